acc_mult_arbiter: RTL

Sequential front end that shares one combinational `acc_mult_unsigned<W1>x<W2>` unit between two requesters. It latches the winning requester's operands, holds them on the unit for a fixed settle window, and captures the unit result. It then returns the result tagged with the requester id over a valid/ready response channel. The block sits between operand producers and the shared multiply-accumulate datapath, and replaces direct instantiation per client.

---
 rtl/acc_mult_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/acc_mult_arbiter.sv
// acc_mult_arbiter: round-robin front end sharing one combinational
// multiply-accumulate unit between two requesters. Operands are latched onto
// the unit, held for SETTLE cycles, and the result returns tagged with the
// requester id over a valid/ready response channel.
module acc_mult_arbiter #(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [WIDTH1-1:0]        req0_a,
  input  logic [WIDTH2-1:0]        req0_b,
  input  logic                     req0_cin,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [WIDTH1-1:0]        req1_a,
  input  logic [WIDTH2-1:0]        req1_b,
  input  logic                     req1_cin,
  output logic [WIDTH1-1:0]        unit_a,
  output logic [WIDTH2-1:0]        unit_b,
  output logic                     unit_cin,
  input  logic [WIDTH1+WIDTH2-1:0] unit_sum,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [WIDTH1+WIDTH2-1:0] rsp_sum,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Settle counter only needs to hold SETTLE-1.
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

  logic [1:0]    state;
  logic          ptr;
  logic [SW-1:0] settle_cnt;
  logic          grant0;
  logic          grant1;
  logic          accept;

  // Arbitration: a lone requester always wins; on contention ptr decides.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !ptr);
    grant1 = req1_valid && (!req0_valid ||  ptr);
  end

  // NOTE: ready is gated by rst as well as state; state already reads IDLE
  // while reset is held, so without the gate a valid could see ready=1.
  assign req0_ready = !rst && (state == IDLE) && grant0;
  assign req1_ready = !rst && (state == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);

  // Control FSM, operand registers, response registers and counters.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      settle_cnt <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      unit_cin   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            unit_a     <= grant0 ? req0_a   : req1_a;
            unit_b     <= grant0 ? req0_b   : req1_b;
            unit_cin   <= grant0 ? req0_cin : req1_cin;
            rsp_id     <= grant1;
            ptr        <= grant0;   // hand priority to the other requester
            settle_cnt <= SETTLE_LOAD;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (settle_cnt == '0) begin
            rsp_sum   <= unit_sum;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
